// File: rtl/spi_master_tx_if.sv
// -----------------------------------------------------------------------------
// spi_master_tx_if
//   Bundles the valid/ready word handshake, the SPI pin group and the frame
//   status flags of spi_master_tx into one connection.
//
//   modport master : the transmitter's view (takes valid/data, drives the rest)
//   modport slave  : the surrounding system's view (data source + pin observer)
//
//   valid     upstream word available
//   data      upstream word, P_DATA_WIDTH bits, sampled only on handshake
//   ready     transmitter can accept a word
//   spi_sclk  SPI clock, idle low
//   spi_mosi  serial data, MSB first, changes on SCLK falling edge
//   spi_cs_n  chip select, active-low
//   busy      frame in progress
//   done      one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
interface spi_master_tx_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic                    valid;
    logic [P_DATA_WIDTH-1:0] data;
    logic                    ready;
    logic                    spi_sclk;
    logic                    spi_mosi;
    logic                    spi_cs_n;
    logic                    busy;
    logic                    done;

    modport master (
        input  valid, data,
        output ready, spi_sclk, spi_mosi, spi_cs_n, busy, done
    );

    modport slave (
        output valid, data,
        input  ready, spi_sclk, spi_mosi, spi_cs_n, busy, done
    );
endinterface

// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
//   SPI mode-0 (CPOL=0, CPHA=0) master transmitter, MSB first. Accepts one
//   P_DATA_WIDTH word per valid/ready handshake and shifts it out framed by
//   spi_cs_n. Every output is a register.
//
//   Frame shape (P = P_CLK_DIV, W = P_DATA_WIDTH):
//     SETUP  P cycles      cs_n low, sclk low, mosi = MSB
//     SHIFT  2*W*P cycles  sclk starts low, toggles every P cycles
//     HOLD   P cycles      cs_n low, sclk low, mosi low
//     IDLE                 cs_n high, ready high, done pulses on entry
//
//   Ports:
//     clk_100  in   system clock, rising edge
//     s_rst    in   synchronous reset, active-high
//     bus      --   spi_master_tx_if.master (handshake, SPI pins, status)
// -----------------------------------------------------------------------------
module spi_master_tx #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CLK_DIV    = 4
) (
    input  logic                  clk_100,
    input  logic                  s_rst,
    spi_master_tx_if.master       bus
);

    localparam int DIV_W = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
    localparam int BIT_W = $clog2(P_DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(P_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [P_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [P_DATA_WIDTH-1:0] shreg_shl;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    ready_q, ready_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    cs_n_q, cs_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    assign shreg_shl = shreg_q << 1;

    // State and output registers.
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            ready_q <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that the registered versions line up with the state they belong to.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        ready_d = 1'b0;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                // ready_q (not ready_d) gates the handshake: the first IDLE
                // cycle after reset shows ready=0 and must not accept.
                if (bus.valid && ready_q) begin
                    state_d = SETUP;
                    shreg_d = bus.data;
                    div_d   = '0;
                    bit_d   = '0;
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    mosi_d  = bus.data[P_DATA_WIDTH-1];
                end
            end

            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: the slave samples the current bit.
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 1'b1;
                    end else begin
                        // Falling edge: present the next bit, or finish once
                        // all W bits have been sampled.
                        sclk_d = 1'b0;
                        if (bit_q < BIT_ALL) begin
                            shreg_d = shreg_shl;
                            mosi_d  = shreg_shl[P_DATA_WIDTH-1];
                        end else begin
                            mosi_d  = 1'b0;
                            state_d = HOLD;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.ready    = ready_q;
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_tx
//   Two instances: default geometry (8 bits, divide-by-4) and the fastest
//   geometry (4 bits, divide-by-1). A pin-level monitor decodes every frame
//   (bits sampled on SCLK rising edges, chip-select length, SCLK spacing) and
//   the scenario tasks compare the decoded frames against values computed from
//   the frame rules: cs_n low for (2W+2)*P cycles, done (2W+2)*P+1 cycles after
//   the handshake, W rising edges spaced 2P cycles apart, data MSB first.
// -----------------------------------------------------------------------------
module tb_spi_master_tx;

    localparam int W8 = 8;
    localparam int P8 = 4;
    localparam int W4 = 4;
    localparam int P4 = 1;

    logic clk_100 = 1'b0;
    logic s_rst8;
    logic s_rst4;

    always #5 clk_100 = ~clk_100;

    spi_master_tx_if #(.P_DATA_WIDTH(W8)) bus8 ();
    spi_master_tx_if #(.P_DATA_WIDTH(W4)) bus4 ();

    spi_master_tx #(.P_DATA_WIDTH(W8), .P_CLK_DIV(P8)) dut8 (
        .clk_100 (clk_100),
        .s_rst   (s_rst8),
        .bus     (bus8.master)
    );

    spi_master_tx #(.P_DATA_WIDTH(W4), .P_CLK_DIV(P4)) dut4 (
        .clk_100 (clk_100),
        .s_rst   (s_rst4),
        .bus     (bus4.master)
    );

    typedef struct {
        logic [7:0] bits;
        int         rises;
        int         cs_len;
        int         high;
        int         bad;
        int         gap;
    } frame_t;

    frame_t frames8[$];
    frame_t frames4[$];

    int n_vec = 0;
    int n_err = 0;

    // monitor state, index 0 = dut8, index 1 = dut4
    int         cyc = 0;
    int         done_cnt [2] = '{0, 0};
    int         idle_bad [2] = '{0, 0};
    int         cs_len   [2];
    int         rises    [2];
    int         high     [2];
    int         bad      [2];
    int         gap      [2];
    int         fgap     [2];
    int         last_rise[2];
    logic [7:0] bits     [2];
    logic       p_sclk   [2];
    logic       p_mosi   [2];
    logic       p_cs     [2];

    // Pin monitor, samples on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk_100);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                logic   rst, sclk, mosi, cs_n, dn, bsy;
                int     hp;
                frame_t f;
                rst  = (k == 0) ? s_rst8        : s_rst4;
                sclk = (k == 0) ? bus8.spi_sclk : bus4.spi_sclk;
                mosi = (k == 0) ? bus8.spi_mosi : bus4.spi_mosi;
                cs_n = (k == 0) ? bus8.spi_cs_n : bus4.spi_cs_n;
                dn   = (k == 0) ? bus8.done     : bus4.done;
                bsy  = (k == 0) ? bus8.busy     : bus4.busy;
                hp   = (k == 0) ? P8 : P4;
                if (rst) begin
                    // a frame cut by reset is abandoned, never reported
                    p_sclk[k] = 1'b0;
                    p_mosi[k] = 1'b0;
                    p_cs[k]   = 1'b1;
                    gap[k]    = 0;
                end else begin
                    if (dn) done_cnt[k]++;
                    if (cs_n) begin
                        if (!p_cs[k]) begin
                            f.bits   = bits[k];
                            f.rises  = rises[k];
                            f.cs_len = cs_len[k];
                            f.high   = high[k];
                            f.bad    = bad[k];
                            f.gap    = fgap[k];
                            if (k == 0) frames8.push_back(f);
                            else        frames4.push_back(f);
                            gap[k] = 0;
                        end
                        gap[k]++;
                        if (sclk || mosi || bsy) idle_bad[k]++;
                    end else begin
                        if (p_cs[k]) begin
                            fgap[k]   = gap[k];
                            cs_len[k] = 0;
                            rises[k]  = 0;
                            high[k]   = 0;
                            bad[k]    = 0;
                            bits[k]   = 8'h00;
                        end
                        cs_len[k]++;
                        if (sclk) high[k]++;
                        if (!bsy) bad[k]++;
                        if (sclk && !p_sclk[k]) begin
                            rises[k]++;
                            bits[k] = {bits[k][6:0], mosi};
                            if (rises[k] > 1 && (cyc - last_rise[k]) != 2 * hp) bad[k]++;
                            last_rise[k] = cyc;
                        end
                        // mode 0: data must be stable while SCLK is high
                        if (sclk && p_sclk[k] && mosi !== p_mosi[k]) bad[k]++;
                    end
                    p_sclk[k] = sclk;
                    p_mosi[k] = mosi;
                    p_cs[k]   = cs_n;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(negedge clk_100);
        #1;
    endtask

    function automatic logic rdy(input int k);
        return (k == 0) ? bus8.ready : bus4.ready;
    endfunction

    function automatic logic dn(input int k);
        return (k == 0) ? bus8.done : bus4.done;
    endfunction

    function automatic logic [5:0] pins(input int k);
        if (k == 0)
            return {bus8.ready, bus8.spi_sclk, bus8.spi_mosi, bus8.spi_cs_n, bus8.busy, bus8.done};
        return {bus4.ready, bus4.spi_sclk, bus4.spi_mosi, bus4.spi_cs_n, bus4.busy, bus4.done};
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? frames8.size() : frames4.size();
    endfunction

    task automatic drive(input int k, input logic v, input logic [7:0] d);
        if (k == 0) begin
            bus8.valid = v;
            bus8.data  = d;
        end else begin
            bus4.valid = v;
            bus4.data  = d[3:0];
        end
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (rdy(k) !== 1'b1 && n < 300) begin step(); n++; end
        n_vec++;
        if (rdy(k) !== 1'b1) begin
            n_err++;
            $display("FAIL ready_wait dut%0d: ready=%b, required 1 within 300 cycles", k, rdy(k));
        end
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (dn(k) !== 1'b1 && lat < 400) begin step(); lat++; end
    endtask

    // One-cycle handshake; data changes to d_after right after it. Returns the
    // handshake-to-done latency in cycles (first cycle after the edge = 1).
    task automatic send(input int k, input logic [7:0] d, input logic [7:0] d_after, output int lat);
        int w;
        wait_ready(k);
        drive(k, 1'b1, d);
        step();
        drive(k, 1'b0, d_after);
        wait_done(k, w);
        lat = w + 1;
    endtask

    task automatic get_frame(input int k, output frame_t f);
        int n = 0;
        f = '{bits: 8'h00, rises: 0, cs_len: 0, high: 0, bad: -1, gap: 0};
        while (qsize(k) == 0 && n < 400) begin step(); n++; end
        n_vec++;
        if (qsize(k) == 0) begin
            n_err++;
            $display("FAIL frame_wait dut%0d: no frame decoded within 400 cycles", k);
        end else if (k == 0) begin
            f = frames8.pop_front();
        end else begin
            f = frames4.pop_front();
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        s_rst8 = 1'b1;
        s_rst4 = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (pins(k) !== 6'b000100) begin
                n_err++;
                $display("FAIL reset_values dut%0d: {ready,sclk,mosi,cs_n,busy,done}=%b required 000100", k, pins(k));
            end
        end
        s_rst8 = 1'b0;
        s_rst4 = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (pins(k) !== 6'b100100) begin
                n_err++;
                $display("FAIL ready_after_reset dut%0d: {ready,sclk,mosi,cs_n,busy,done}=%b required 100100", k, pins(k));
            end
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            int         lat, dc0;
            frame_t     f;
            d   = (i == 0) ? 8'hA5 : 8'($urandom);
            dc0 = done_cnt[0];
            send(0, d, 8'($urandom), lat);
            n_vec++;
            if (lat !== (2 * W8 + 2) * P8 + 1) begin
                n_err++;
                $display("FAIL single_latency d=%h: got %0d cycles, required %0d", d, lat, (2 * W8 + 2) * P8 + 1);
            end
            n_vec++;
            if ({bus8.ready, bus8.spi_cs_n, bus8.done} !== 3'b111) begin
                n_err++;
                $display("FAIL single_end d=%h: {ready,cs_n,done}=%b required 111", d, {bus8.ready, bus8.spi_cs_n, bus8.done});
            end
            step();
            n_vec++;
            if (bus8.done !== 1'b0) begin
                n_err++;
                $display("FAIL single_done_width d=%h: done=%b one cycle later, required 0", d, bus8.done);
            end
            get_frame(0, f);
            n_vec++;
            if (f.bits !== d) begin
                n_err++;
                $display("FAIL single_bits: got %h required %h", f.bits, d);
            end
            n_vec++;
            if (f.cs_len != (2 * W8 + 2) * P8) begin
                n_err++;
                $display("FAIL single_cs_len d=%h: got %0d required %0d", d, f.cs_len, (2 * W8 + 2) * P8);
            end
            n_vec++;
            if (f.rises != W8 || f.high != W8 * P8) begin
                n_err++;
                $display("FAIL single_sclk d=%h: rises=%0d high=%0d required %0d/%0d", d, f.rises, f.high, W8, W8 * P8);
            end
            n_vec++;
            if (f.bad != 0) begin
                n_err++;
                $display("FAIL single_timing d=%h: %0d period/stability/busy violations, required 0", d, f.bad);
            end
            n_vec++;
            if (done_cnt[0] - dc0 != 1) begin
                n_err++;
                $display("FAIL single_done_count d=%h: got %0d pulses required 1", d, done_cnt[0] - dc0);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 2; it++) begin
            logic [7:0] d0, d1;
            int         dc0, w;
            frame_t     f0, f1;
            d0 = (it == 0) ? 8'h3C : 8'($urandom);
            d1 = (it == 0) ? 8'hFF : 8'($urandom);
            wait_ready(0);
            dc0 = done_cnt[0];
            drive(0, 1'b1, d0);
            step();
            drive(0, 1'b1, d1);
            wait_done(0, w);
            step();
            drive(0, 1'b0, 8'($urandom));
            wait_done(0, w);
            get_frame(0, f0);
            get_frame(0, f1);
            n_vec++;
            if (f0.bits !== d0 || f1.bits !== d1) begin
                n_err++;
                $display("FAIL b2b_bits: got %h,%h required %h,%h", f0.bits, f1.bits, d0, d1);
            end
            n_vec++;
            if (f1.gap != 1) begin
                n_err++;
                $display("FAIL b2b_cs_gap: cs_n high %0d cycles between frames, required 1", f1.gap);
            end
            n_vec++;
            if (f1.cs_len != (2 * W8 + 2) * P8 || f1.bad != 0) begin
                n_err++;
                $display("FAIL b2b_second_frame: cs_len=%0d bad=%0d required %0d/0", f1.cs_len, f1.bad, (2 * W8 + 2) * P8);
            end
            n_vec++;
            if (done_cnt[0] - dc0 != 2) begin
                n_err++;
                $display("FAIL b2b_done_count: got %0d pulses required 2", done_cnt[0] - dc0);
            end
        end
    endtask

    task automatic test_valid_without_ready();
        logic [7:0] d;
        int         dc0, w;
        frame_t     f;
        d = 8'($urandom);
        wait_ready(0);
        dc0 = done_cnt[0];
        drive(0, 1'b1, d);
        step();
        drive(0, 1'b0, 8'($urandom));
        repeat (10) step();
        drive(0, 1'b1, 8'h11);
        repeat (20) step();
        drive(0, 1'b0, 8'h11);
        wait_done(0, w);
        repeat (100) step();
        n_vec++;
        if (frames8.size() != 1) begin
            n_err++;
            $display("FAIL nrdy_frame_count: got %0d frames required 1", frames8.size());
        end
        get_frame(0, f);
        n_vec++;
        if (f.bits !== d) begin
            n_err++;
            $display("FAIL nrdy_bits: got %h required %h", f.bits, d);
        end
        n_vec++;
        if (done_cnt[0] - dc0 != 1) begin
            n_err++;
            $display("FAIL nrdy_done_count: got %0d pulses required 1", done_cnt[0] - dc0);
        end
        n_vec++;
        if (pins(0) !== 6'b100100) begin
            n_err++;
            $display("FAIL nrdy_idle: {ready,sclk,mosi,cs_n,busy,done}=%b required 100100", pins(0));
        end
    endtask

    task automatic test_data_change();
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d, d_after;
            int         lat;
            frame_t     f;
            d       = (i == 0) ? 8'h80 : 8'($urandom);
            d_after = (i == 0) ? 8'h01 : ~d;
            send(0, d, d_after, lat);
            get_frame(0, f);
            n_vec++;
            if (f.bits !== d) begin
                n_err++;
                $display("FAIL data_change: got %h required %h (data changed to %h)", f.bits, d, d_after);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int         dc0, n, lat;
        frame_t     f;
        d = 8'($urandom);
        wait_ready(0);
        drive(0, 1'b1, d);
        step();
        drive(0, 1'b0, 8'($urandom));
        dc0 = done_cnt[0];
        n   = 0;
        while (rises[0] < 3 && n < 400) begin step(); n++; end
        n_vec++;
        if (rises[0] != 3) begin
            n_err++;
            $display("FAIL rst_mid_third_edge: saw %0d rising edges, required 3", rises[0]);
        end
        s_rst8 = 1'b1;
        step();
        n_vec++;
        if (pins(0) !== 6'b000100) begin
            n_err++;
            $display("FAIL rst_mid_outputs: {ready,sclk,mosi,cs_n,busy,done}=%b required 000100", pins(0));
        end
        s_rst8 = 1'b0;
        step();
        n_vec++;
        if (bus8.ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ready: ready=%b required 1", bus8.ready);
        end
        n_vec++;
        if (frames8.size() != 0 || done_cnt[0] != dc0) begin
            n_err++;
            $display("FAIL rst_mid_abandon: frames=%0d done_pulses=%0d required 0/0", frames8.size(), done_cnt[0] - dc0);
        end
        send(0, 8'h5A, 8'($urandom), lat);
        get_frame(0, f);
        n_vec++;
        if (f.bits !== 8'h5A || f.cs_len != (2 * W8 + 2) * P8 || f.bad != 0) begin
            n_err++;
            $display("FAIL rst_mid_resume: bits=%h cs_len=%0d bad=%0d required 5a/%0d/0", f.bits, f.cs_len, f.bad, (2 * W8 + 2) * P8);
        end
        n_vec++;
        if (lat != (2 * W8 + 2) * P8 + 1) begin
            n_err++;
            $display("FAIL rst_mid_latency: got %0d required %0d", lat, (2 * W8 + 2) * P8 + 1);
        end
    endtask

    task automatic test_clk_div1();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            int         lat;
            frame_t     f;
            d = (i == 0) ? 8'h0C : {4'h0, 4'($urandom)};
            send(1, d, 8'($urandom), lat);
            n_vec++;
            if (lat != (2 * W4 + 2) * P4 + 1) begin
                n_err++;
                $display("FAIL div1_latency d=%h: got %0d required %0d", d, lat, (2 * W4 + 2) * P4 + 1);
            end
            get_frame(1, f);
            n_vec++;
            if (f.bits !== d) begin
                n_err++;
                $display("FAIL div1_bits: got %h required %h", f.bits, d);
            end
            n_vec++;
            if (f.cs_len != (2 * W4 + 2) * P4) begin
                n_err++;
                $display("FAIL div1_cs_len d=%h: got %0d required %0d", d, f.cs_len, (2 * W4 + 2) * P4);
            end
            n_vec++;
            if (f.rises != W4 || f.high != W4 * P4 || f.bad != 0) begin
                n_err++;
                $display("FAIL div1_sclk d=%h: rises=%0d high=%0d bad=%0d required %0d/%0d/0", d, f.rises, f.high, f.bad, W4, W4 * P4);
            end
        end
    endtask

    task automatic test_idle_lines();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (idle_bad[k] != 0) begin
                n_err++;
                $display("FAIL idle_lines dut%0d: %0d idle cycles with sclk/mosi/busy high, required 0", k, idle_bad[k]);
            end
        end
    endtask

    initial begin
        s_rst8 = 1'b1;
        s_rst4 = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_valid_without_ready();
        test_data_change();
        test_reset_mid_frame();
        test_clk_div1();
        test_idle_lines();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
